led_frame_write_arbiter: RTL and testbench



---
 rtl/led_frame_write_arbiter_if.sv | 45 ++++
 rtl/led_frame_write_arbiter.sv | 149 ++++++++++++++
 tb/tb_led_frame_write_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_frame_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// led_frame_write_arbiter_if
// Purpose : bundles the two requester write-burst channels and frame-RAM write
//           port A into one connection for led_frame_write_arbiter.
// Signals : req0_* / req1_*  valid/ready beat handshake with word address,
//                            32-bit data and end-of-burst marker.
//           ram_*            port A byte write enables, byte address and data.
// Modports: slave  - the arbiter (consumes requests, drives RAM port A)
//           master - the requesters / RAM side (drives requests)
// -----------------------------------------------------------------------------
interface led_frame_write_arbiter_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              req0_valid_in;
   logic              req0_ready_out;
   logic [ADDR_W-1:0] req0_addr_in;
   logic [31:0]       req0_data_in;
   logic              req0_last_in;

   logic              req1_valid_in;
   logic              req1_ready_out;
   logic [ADDR_W-1:0] req1_addr_in;
   logic [31:0]       req1_data_in;
   logic              req1_last_in;

   logic [3:0]        ram_wena_out;
   logic [31:0]       ram_addra_out;
   logic [31:0]       ram_dina_out;

   modport slave (
      input  req0_valid_in, req0_addr_in, req0_data_in, req0_last_in,
      output req0_ready_out,
      input  req1_valid_in, req1_addr_in, req1_data_in, req1_last_in,
      output req1_ready_out,
      output ram_wena_out, ram_addra_out, ram_dina_out
   );

   modport master (
      output req0_valid_in, req0_addr_in, req0_data_in, req0_last_in,
      input  req0_ready_out,
      output req1_valid_in, req1_addr_in, req1_data_in, req1_last_in,
      input  req1_ready_out,
      input  ram_wena_out, ram_addra_out, ram_dina_out
   );
endinterface

// File: rtl/led_frame_write_arbiter.sv
// -----------------------------------------------------------------------------
// led_frame_write_arbiter
// Purpose : owns write port A of the ping-pong frame RAM. Round-robin
//           arbitration between requester 0 (host frame loader) and
//           requester 1 (test-pattern generator) with whole-burst locking.
//           Writes land in the write bank; port B reads the other bank. Banks
//           swap only at a frame boundary reported by the read controller.
// Ports   : clk_in, n_reset_in     clock, async active-low reset
//           bus (slave)            requester channels + RAM port A
//           swap_req_in            pulse: request a bank swap
//           frame_done_in          pulse: read side finished a frame
//           read_bank_out          bank seen by port B (port B address MSB)
//           write_bank_out         bank targeted by writes (= !read_bank_out)
//           swap_done_out          one-cycle pulse after a swap takes effect
//           addr_err_out           one-cycle pulse after an out-of-range beat
// -----------------------------------------------------------------------------
module led_frame_write_arbiter #(
   parameter int unsigned FRAME_WORDS = 1024,
   parameter int unsigned ADDR_W      = 10
) (
   input  logic                           clk_in,
   input  logic                           n_reset_in,
   led_frame_write_arbiter_if.slave       bus,
   input  logic                           swap_req_in,
   input  logic                           frame_done_in,
   output logic                           read_bank_out,
   output logic                           write_bank_out,
   output logic                           swap_done_out,
   output logic                           addr_err_out
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t            state_q, state_d;
   logic              ptr_q, ptr_d;        // requester favoured on a tie
   logic              swap_pending_q;
   logic              read_bank_q;
   logic [3:0]        wena_q;
   logic [31:0]       addra_q;
   logic [31:0]       dina_q;
   logic              addr_err_q;
   logic              swap_done_q;

   logic              acc0, acc1, acc;
   logic [ADDR_W-1:0] beat_addr;
   logic [31:0]       beat_data;
   logic              beat_last;
   logic              in_range;
   logic              swap_now;

   // Ready is a pure decode of the grant state, so it is 0 out of reset and
   // rises the cycle after the grant decision.
   assign bus.req0_ready_out = (state_q == GRANT0);
   assign bus.req1_ready_out = (state_q == GRANT1);

   assign acc0 = bus.req0_ready_out & bus.req0_valid_in;
   assign acc1 = bus.req1_ready_out & bus.req1_valid_in;
   assign acc  = acc0 | acc1;

   assign beat_addr = acc1 ? bus.req1_addr_in : bus.req0_addr_in;
   assign beat_data = acc1 ? bus.req1_data_in : bus.req0_data_in;
   assign beat_last = acc1 ? bus.req1_last_in : bus.req0_last_in;
   assign in_range  = 32'(beat_addr) < FRAME_WORDS;

   // A swap never lands while a burst owns the port or while the last write
   // of a burst is still sitting in the output register, so a burst always
   // completes entirely inside one bank.
   assign swap_now = (swap_pending_q | swap_req_in) & frame_done_in &
                     (state_q == IDLE) & (wena_q == 4'h0);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            // A pending swap freezes new grants until the frame boundary.
            if (!swap_pending_q) begin
               if (bus.req0_valid_in && bus.req1_valid_in)
                  state_d = ptr_q ? GRANT1 : GRANT0;
               else if (bus.req0_valid_in)
                  state_d = GRANT0;
               else if (bus.req1_valid_in)
                  state_d = GRANT1;
            end
         end
         GRANT0: begin
            if (acc0 && bus.req0_last_in) begin
               state_d = IDLE;
               ptr_d   = 1'b1;
            end
         end
         GRANT1: begin
            if (acc1 && bus.req1_last_in) begin
               state_d = IDLE;
               ptr_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge n_reset_in) begin
      if (!n_reset_in) begin
         state_q        <= IDLE;
         ptr_q          <= 1'b0;
         swap_pending_q <= 1'b0;
         read_bank_q    <= 1'b0;
         wena_q         <= 4'h0;
         addra_q        <= 32'h0;
         dina_q         <= 32'h0;
         addr_err_q     <= 1'b0;
         swap_done_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         swap_done_q <= swap_now;
         addr_err_q  <= acc & ~in_range;

         if (swap_now) begin
            read_bank_q    <= ~read_bank_q;
            swap_pending_q <= 1'b0;
         end else if (swap_req_in) begin
            swap_pending_q <= 1'b1;
         end

         // Out-of-range beats are handshaken but leave address/data holding.
         if (acc && in_range) begin
            wena_q  <= 4'hF;
            addra_q <= 32'({~read_bank_q, beat_addr, 2'b00});
            dina_q  <= beat_data;
         end else begin
            wena_q  <= 4'h0;
         end
      end
   end

   assign bus.ram_wena_out  = wena_q;
   assign bus.ram_addra_out = addra_q;
   assign bus.ram_dina_out  = dina_q;
   assign read_bank_out     = read_bank_q;
   assign write_bank_out    = ~read_bank_q;
   assign swap_done_out     = swap_done_q;
   assign addr_err_out      = addr_err_q;

endmodule

// File: tb/tb_led_frame_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_led_frame_write_arbiter
// Purpose : self-checking bench for led_frame_write_arbiter. A cycle-level
//           behavioural model (owner/pointer/pending/bank variables) predicts
//           every output and is compared on each falling edge; directed
//           sections pin the model with hand-computed literal values.
// Note    : the DUT is built with FRAME_WORDS = 1000 so that words at and above
//           the frame limit are expressible on a 10-bit address port; the
//           bank bit is still bit 12 (0x1000).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_frame_write_arbiter;
   localparam int unsigned FW = 1000;
   localparam int unsigned AW = 10;

   logic clk        = 1'b0;
   logic rst_n      = 1'b0;
   logic swap_req   = 1'b0;
   logic frame_done = 1'b0;
   logic read_bank, write_bank, swap_done, addr_err;

   led_frame_write_arbiter_if #(.ADDR_W(AW)) bus();

   led_frame_write_arbiter #(.FRAME_WORDS(FW), .ADDR_W(AW)) dut (
      .clk_in         (clk),
      .n_reset_in     (rst_n),
      .bus            (bus.slave),
      .swap_req_in    (swap_req),
      .frame_done_in  (frame_done),
      .read_bank_out  (read_bank),
      .write_bank_out (write_bank),
      .swap_done_out  (swap_done),
      .addr_err_out   (addr_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_owner   = -1;   // -1: nobody owns the port
   int          m_ptr     = 0;
   bit          m_pending = 1'b0;
   bit          m_rbank   = 1'b0;
   logic [3:0]  e_wena    = 4'h0;
   logic [31:0] e_addra   = 32'h0;
   logic [31:0] e_dina    = 32'h0;
   bit          e_err     = 1'b0;
   bit          e_swapd   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      bit          acc, lst, swp, v0, v1;
      int          a;
      logic [31:0] d;
      if (!rst_n) begin
         m_owner = -1; m_ptr = 0; m_pending = 0; m_rbank = 0;
         e_wena = 4'h0; e_addra = 0; e_dina = 0; e_err = 0; e_swapd = 0;
      end else begin
         v0 = bus.req0_valid_in; v1 = bus.req1_valid_in;
         acc = 0; lst = 0; a = 0; d = 0;
         if (m_owner == 0 && v0) begin
            acc = 1; a = int'(bus.req0_addr_in); d = bus.req0_data_in; lst = bus.req0_last_in;
         end
         if (m_owner == 1 && v1) begin
            acc = 1; a = int'(bus.req1_addr_in); d = bus.req1_data_in; lst = bus.req1_last_in;
         end
         swp = (m_pending || swap_req) && frame_done && m_owner < 0 && e_wena == 4'h0;

         e_err   = acc && a >= int'(FW);
         e_swapd = swp;
         if (acc && a < int'(FW)) begin
            e_wena  = 4'hF;
            e_addra = 32'((m_rbank ? 0 : 1) * (1 << (AW + 2)) + a * 4);
            e_dina  = d;
         end else begin
            e_wena  = 4'h0;
         end

         if (m_owner < 0) begin
            if (!m_pending) begin
               if (v0 && v1)  m_owner = m_ptr;
               else if (v0)   m_owner = 0;
               else if (v1)   m_owner = 1;
            end
         end else if (acc && lst) begin
            m_ptr   = 1 - m_owner;
            m_owner = -1;
         end

         if (swp) begin
            m_rbank   = !m_rbank;
            m_pending = 0;
         end else if (swap_req) begin
            m_pending = 1;
         end
      end
   end

   // ---------------- compare process + event logs ----------------
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          done_log[$];
   int          swap_cnt = 0;
   int          err_cnt  = 0;

   always @(negedge clk) begin
      check("ready0",     {31'b0, bus.req0_ready_out}, {31'b0, m_owner == 0});
      check("ready1",     {31'b0, bus.req1_ready_out}, {31'b0, m_owner == 1});
      check("wena",       {28'b0, bus.ram_wena_out},   {28'b0, e_wena});
      check("addra",      bus.ram_addra_out,           e_addra);
      check("dina",       bus.ram_dina_out,            e_dina);
      check("addr_err",   {31'b0, addr_err},           {31'b0, e_err});
      check("swap_done",  {31'b0, swap_done},          {31'b0, e_swapd});
      check("read_bank",  {31'b0, read_bank},          {31'b0, m_rbank});
      check("write_bank", {31'b0, write_bank},         {31'b0, !m_rbank});
      if (bus.ram_wena_out == 4'hF) begin
         wr_addr.push_back(bus.ram_addra_out);
         wr_data.push_back(bus.ram_dina_out);
      end
      if (swap_done) swap_cnt++;
      if (addr_err)  err_cnt++;
      if (bus.req0_ready_out && bus.req0_valid_in && bus.req0_last_in) done_log.push_back(0);
      if (bus.req1_ready_out && bus.req1_valid_in && bus.req1_last_in) done_log.push_back(1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int r, input bit v, input int a, input logic [31:0] d, input bit l);
      if (r == 0) begin
         bus.req0_valid_in = v; bus.req0_addr_in = AW'(a);
         bus.req0_data_in  = d; bus.req0_last_in = l;
      end else begin
         bus.req1_valid_in = v; bus.req1_addr_in = AW'(a);
         bus.req1_data_in  = d; bus.req1_last_in = l;
      end
   endtask

   // Returns just after the edge that accepted the current beat.
   task automatic wait_ready(input int r);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if ((r == 0) ? bus.req0_ready_out : bus.req1_ready_out) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      check("ready_timeout", 32'd1, 32'd0);
   endtask

   task automatic burst(input int r, input int a0, input int n,
                        input logic [31:0] d0, input logic [31:0] dstep);
      for (int i = 0; i < n; i++) begin
         drive(r, 1'b1, a0 + i, d0 + 32'(i) * dstep, i == n - 1);
         wait_ready(r);
      end
      drive(r, 1'b0, 0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      cycles(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] exp_a[4];
      logic [31:0] exp_d[4];
      int s0, e0, w0;
      exp_a = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
      exp_d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      drive(0, 1'b0, 0, 32'h0, 1'b0);
      drive(1, 1'b0, 0, 32'h0, 1'b0);

      // Reset values while reset is held.
      cycles(2);
      check("rst_ready0",     {31'b0, bus.req0_ready_out}, 32'd0);
      check("rst_ready1",     {31'b0, bus.req1_ready_out}, 32'd0);
      check("rst_wena",       {28'b0, bus.ram_wena_out},   32'd0);
      check("rst_addra",      bus.ram_addra_out,           32'd0);
      check("rst_read_bank",  {31'b0, read_bank},          32'd0);
      check("rst_write_bank", {31'b0, write_bank},         32'd1);
      rst_n = 1'b1;
      cycles(1);

      // 4-beat burst from requester 0 into bank 1.
      wr_addr.delete(); wr_data.delete();
      burst(0, 0, 4, 32'h11111111, 32'h11111111);
      cycles(2);
      check("t1_write_count", 32'(wr_addr.size()), 32'd4);
      for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
         check("t1_addr", wr_addr[i], exp_a[i]);
         check("t1_data", wr_data[i], exp_d[i]);
      end

      // Both requesters continuously valid with 2-beat bursts.
      do_reset();
      done_log.delete();
      fork
         begin burst(0, 16, 2, 32'hA0000000, 32'h1); burst(0, 32, 2, 32'hA1000000, 32'h1); end
         begin burst(1, 48, 2, 32'hB0000000, 32'h1); burst(1, 64, 2, 32'hB1000000, 32'h1); end
      join
      cycles(2);
      check("t2_bursts", 32'(done_log.size()), 32'd4);
      if (done_log.size() == 4) begin
         check("t2_order0", 32'(done_log[0]), 32'd0);
         check("t2_order1", 32'(done_log[1]), 32'd1);
         check("t2_order2", 32'(done_log[2]), 32'd0);
         check("t2_order3", 32'(done_log[3]), 32'd1);
      end

      // Swap with both requesters idle.
      s0 = swap_cnt;
      swap_req = 1'b1; cycles(1); swap_req = 1'b0;
      cycles(4);
      frame_done = 1'b1; cycles(1); frame_done = 1'b0;
      check("t3_read_bank",  {31'b0, read_bank},  32'd1);
      check("t3_write_bank", {31'b0, write_bank}, 32'd0);
      check("t3_swap_done",  {31'b0, swap_done},  32'd1);
      cycles(1);
      check("t3_swap_done_low", {31'b0, swap_done}, 32'd0);
      check("t3_swap_count",    32'(swap_cnt - s0), 32'd1);
      wr_addr.delete(); wr_data.delete();
      burst(1, 0, 1, 32'hCAFE0001, 32'h0);
      cycles(2);
      check("t3_write_count", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() == 1) check("t3_addr", wr_addr[0], 32'h0000_0000);

      // Swap request and frame_done during a 3-beat req1 burst.
      s0 = swap_cnt;
      wr_addr.delete(); wr_data.delete();
      fork
         burst(1, 256, 3, 32'hC0000000, 32'h1);
         begin
            for (int c = 0; c < 50 && !bus.req1_ready_out; c++) @(negedge clk);
            @(posedge clk); #1;
            swap_req = 1'b1; frame_done = 1'b1;
            cycles(1);
            frame_done = 1'b0;            // repeated swap request, still in burst
            cycles(1);
            swap_req = 1'b0;
         end
      join
      check("t4_no_swap_bank",  {31'b0, read_bank},  32'd1);
      check("t4_no_swap_count", 32'(swap_cnt - s0), 32'd0);
      fork
         burst(0, 5, 2, 32'hD0000000, 32'h1);
         begin
            cycles(4);
            check("t4_blocked", {31'b0, bus.req0_ready_out}, 32'd0);
            frame_done = 1'b1; cycles(1); frame_done = 1'b0;
         end
      join
      cycles(2);
      check("t4_swap_count", 32'(swap_cnt - s0), 32'd1);
      check("t4_read_bank",  {31'b0, read_bank}, 32'd0);
      check("t4_write_count", 32'(wr_addr.size()), 32'd5);
      if (wr_addr.size() == 5) begin
         check("t4_req1_addr", wr_addr[0], 32'h0000_0400);
         check("t4_req0_addr", wr_addr[3], 32'h0000_1014);
         check("t4_req0_last", wr_addr[4], 32'h0000_1018);
      end

      // Out-of-range beats: the limit itself and the top of the address space.
      e0 = err_cnt;
      w0 = wr_addr.size();
      burst(0, 1000, 1, 32'hEEEE0000, 32'h0);
      cycles(2);
      check("t5_err_once",   32'(err_cnt - e0), 32'd1);
      check("t5_no_write",   32'(wr_addr.size() - w0), 32'd0);
      burst(0, 999, 1, 32'h99999999, 32'h0);
      cycles(2);
      check("t5_edge_write", 32'(wr_addr.size() - w0), 32'd1);
      if (wr_addr.size() > w0) check("t5_edge_addr", wr_addr[w0], 32'h0000_1F9C);
      burst(0, 1023, 1, 32'hEEEE0001, 32'h0);
      cycles(2);
      check("t5_err_twice",  32'(err_cnt - e0), 32'd2);

      // Reset asserted during beat 2 of a 4-beat burst.
      drive(0, 1'b1, 0, 32'hF0, 1'b0); wait_ready(0);
      drive(0, 1'b1, 1, 32'hF1, 1'b0); wait_ready(0);
      drive(0, 1'b1, 2, 32'hF2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_ready0",     {31'b0, bus.req0_ready_out}, 32'd0);
      check("t6_wena",       {28'b0, bus.ram_wena_out},   32'd0);
      check("t6_addra",      bus.ram_addra_out,           32'd0);
      check("t6_dina",       bus.ram_dina_out,            32'd0);
      check("t6_write_bank", {31'b0, write_bank},         32'd1);
      drive(0, 1'b0, 0, 32'h0, 1'b0);
      cycles(2);
      rst_n = 1'b1;
      w0 = wr_addr.size();
      cycles(5);
      check("t6_no_writes", 32'(wr_addr.size() - w0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
